// File: rtl/seg_pkg.sv
// Shared segment encodings and hex decode helper for the LED scan display.
package seg_pkg;

  localparam int DIGIT_W = 2;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high {g,f,e,d,c,b,a}; b and d are lowercase glyphs.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_OFF;
    unique case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-high 7-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/led_seg_scan.sv
// 4-digit hex scan of sampled CPU led_addr/led bytes.
// Define SEG_LZ_BLANK_EN for leading-zero blanking of digits 3 and 1.
module led_seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int HOLD_CYCLES    = 5000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] led,
  input  logic [7:0] led_addr,
  input  logic       freeze,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       sample_tick
);

  localparam int SCW = $clog2(SCAN_DIV);
  localparam int SMW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCW-1:0] SCAN_LAST =
    SCW'(SCAN_DIV - 1);
  localparam logic [SMW-1:0] SMP_LAST =
    SMW'(HOLD_CYCLES - 1);
  localparam logic [6:0] SEG_IDLE =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic DP_IDLE = SEG_ACTIVE_LOW;

  logic [SCW-1:0]     scan_cnt;
  logic [SMW-1:0]     sample_cnt;
  logic [DIGIT_W-1:0] digit_idx;
  logic [7:0]         hold_led;
  logic [7:0]         hold_addr;

  logic       capture;
  logic       scan_wrap;
  logic [3:0] nib;
  logic [6:0] dec;
  logic [6:0] seg_hi;
  logic       blank;
  logic       dp_lit;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  assign capture   = (sample_cnt == '0) && !freeze;
  assign scan_wrap = (scan_cnt == SCAN_LAST);

  hex7seg u_hex (
    .nib (nib),
    .seg (dec)
  );

  always_comb begin
    nib = hold_led[3:0];
    unique case (digit_idx)
      2'd0: nib = hold_led[3:0];
      2'd1: nib = hold_led[7:4];
      2'd2: nib = hold_addr[3:0];
      2'd3: nib = hold_addr[7:4];
    endcase
  end

  always_comb begin
    blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    blank =
      ((digit_idx == 2'd3) && (hold_addr[7:4] == 4'h0)) ||
      ((digit_idx == 2'd1) && (hold_led[7:4] == 4'h0));
`endif
    seg_hi  = blank ? SEG_OFF : dec;
    dp_lit  = (digit_idx == 2'd2);
    an_nxt  = ~(4'b0001 << digit_idx);
    seg_nxt = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    dp_nxt  = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt  <= '0;
      hold_led    <= '0;
      hold_addr   <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_cnt  <= (sample_cnt == SMP_LAST) ?
                     '0 : sample_cnt + 1'b1;
      sample_tick <= capture;
      if (capture) begin
        hold_led  <= led;
        hold_addr <= led_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) digit_idx <= digit_idx + 1'b1;
    end
  end

  // Output register lags digit_idx/hold_* by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_IDLE;
      dp  <= DP_IDLE;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_led_seg_scan.sv
// Directed bench for led_seg_scan (SCAN_DIV=4, HOLD_CYCLES=8).
module tb_led_seg_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led;
  logic [7:0] led_addr;
  logic       freeze;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       sample_tick;

  int checks = 0;
  int errors = 0;
  int k = 0;

  always #5 clk = ~clk;

  led_seg_scan #(
    .SCAN_DIV       (4),
    .HOLD_CYCLES    (8),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .led         (led),
    .led_addr    (led_addr),
    .freeze      (freeze),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .sample_tick (sample_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d got %h exp %h", tag, k, obs, exp);
    end
  endtask

  task automatic disp(input string tag,
                      input logic [3:0] an_e,
                      input logic [6:0] seg_e,
                      input logic dp_e);
    chk({tag, "_an"}, {4'h0, an}, {4'h0, an_e});
    chk({tag, "_seg"}, {1'b0, seg}, {1'b0, seg_e});
    chk({tag, "_dp"}, {7'h0, dp}, {7'h0, dp_e});
  endtask

  initial begin
    rst      = 1'b1;
    led      = 8'hA5;
    led_addr = 8'h00;
    freeze   = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      disp("rst", 4'b1111, 7'h7F, 1'b1);
      chk("rst_tick", {7'h0, sample_tick}, 8'h0);
    end
    rst = 1'b0;
    k = 0;

    step();
    chk("cap1_tick", {7'h0, sample_tick}, 8'h1);
    disp("e1", 4'b1110, 7'h40, 1'b1);
    led      = 8'h5A;
    led_addr = 8'h3C;
    step();
    chk("e2_tick", {7'h0, sample_tick}, 8'h0);
    disp("e2_a5lo", 4'b1110, 7'h12, 1'b1);

    run_to(5);
    disp("e5_a5hi", 4'b1101, 7'h08, 1'b1);
    run_to(9);
    disp("e9_addr0", 4'b1011, 7'h40, 1'b0);
    chk("e9_tick", {7'h0, sample_tick}, 8'h1);
    run_to(13);
    disp("e13_d3", 4'b0111, 7'h30, 1'b1);
    run_to(17);
    disp("e17_d0", 4'b1110, 7'h08, 1'b1);
    run_to(21);
    disp("e21_d1", 4'b1101, 7'h12, 1'b1);
    run_to(25);
    disp("e25_d2", 4'b1011, 7'h46, 1'b0);
    run_to(29);
    disp("e29_d3", 4'b0111, 7'h30, 1'b1);

    run_to(32);
    while (k < 56) begin
      led = 8'(k + 1);
      step();
      chk("rate_tick", {7'h0, sample_tick},
          {7'h0, ((k - 1) % 8) == 0});
      if (k == 49) disp("rate_49", 4'b1110, 7'h10, 1'b1);
      if (k == 50) disp("rate_50", 4'b1110, 7'h79, 1'b1);
    end

    led    = 8'hFF;
    freeze = 1'b1;
    while (k < 65) begin
      if (k == 60) freeze = 1'b0;
      step();
      chk("frz_tick", {7'h0, sample_tick},
          {7'h0, k == 65});
    end
    disp("frz_hold", 4'b1110, 7'h79, 1'b1);
    step();
    disp("frz_new", 4'b1110, 7'h0E, 1'b1);

    run_to(74);
    disp("pre_rst", 4'b1011, 7'h46, 1'b0);
    rst = 1'b1;
    step();
    disp("mid_rst", 4'b1111, 7'h7F, 1'b1);
    chk("mid_rst_tick", {7'h0, sample_tick}, 8'h0);
    rst = 1'b0;
    k = 0;
    step();
    disp("rs_e1", 4'b1110, 7'h40, 1'b1);
    chk("rs_tick", {7'h0, sample_tick}, 8'h1);
    step();
    disp("rs_e2", 4'b1110, 7'h0E, 1'b1);

    led      = 8'h00;
    led_addr = 8'h07;
    run_to(10);
    disp("lz_d2", 4'b1011, 7'h78, 1'b0);
    run_to(13);
`ifdef SEG_LZ_BLANK_EN
    disp("lz_d3", 4'b0111, 7'h7F, 1'b1);
`else
    disp("lz_d3", 4'b0111, 7'h40, 1'b1);
`endif
    run_to(17);
    disp("lz_d0", 4'b1110, 7'h40, 1'b1);
    run_to(21);
`ifdef SEG_LZ_BLANK_EN
    disp("lz_d1", 4'b1101, 7'h7F, 1'b1);
`else
    disp("lz_d1", 4'b1101, 7'h40, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
